// File: rtl/address_ring_decoder_pkg.sv
// Shared widths, reset constants and FSM encoding for the address ring decoder.
package address_ring_decoder_pkg;

  localparam int DATANUM = 15;
  localparam int ADDRESS = 4;

  localparam logic [DATANUM-1:0] RING_RESET   = 15'b100_0000_0000_0000;
  localparam logic [ADDRESS-1:0] ADDR_INVALID = 4'd15;
  localparam logic [ADDRESS-1:0] ADDR_LAST    = 4'(DATANUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/addr_onehot_decode.sv
// Binary address to one-hot ring select: address 0 is bit 14, address k is bit k-1.
// Purely combinational; address 15 yields an all-zero select.
module addr_onehot_decode
  import address_ring_decoder_pkg::*;
(
  input  logic [ADDRESS-1:0] addr_i,
  output logic [DATANUM-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (addr_i == '0) begin
      onehot_o[DATANUM-1] = 1'b1;
    end else if (addr_i != ADDR_INVALID) begin
      onehot_o[addr_i - 4'd1] = 1'b1;
    end
  end

endmodule

// File: rtl/address_ring_decoder.sv
// Loads a binary address into a 15-bit one-hot ring and rotates it on Shift or for Len steps on Start.
// All outputs registered, one cycle after the sampling edge; Load > Start > Shift, no backpressure.
module address_ring_decoder
  import address_ring_decoder_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               Load,
  input  logic [ADDRESS-1:0] AddrIn,
  input  logic               Shift,
  input  logic               Start,
  input  logic [ADDRESS-1:0] Len,
  output logic [DATANUM-1:0] RingOut,
  output logic [ADDRESS-1:0] AddrOut,
  output logic               Valid,
  output logic               Busy,
  output logic               Done,
  output logic               Wrap,
  output logic               Error
);

  state_e             state_q;
  logic [ADDRESS-1:0] cnt_q;
  logic [DATANUM-1:0] ring_q;
  logic [ADDRESS-1:0] addr_q;
  logic               valid_q;
  logic               wrap_q;
  logic               error_q;

  logic [DATANUM-1:0] ring_dec;
  logic [DATANUM-1:0] ring_adv;
  logic [ADDRESS-1:0] addr_adv;

  addr_onehot_decode u_decode (
    .addr_i   (AddrIn),
    .onehot_o (ring_dec)
  );

  // One ring step: rotate left, binary index follows mod 15.
  always_comb begin
    ring_adv = {ring_q[DATANUM-2:0], ring_q[DATANUM-1]};
    addr_adv = (addr_q == ADDR_LAST) ? '0 : addr_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ring_q  <= RING_RESET;
      addr_q  <= '0;
      valid_q <= 1'b1;
      wrap_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (Load) begin
        // A load always aborts a run silently, even an invalid one.
        ring_q  <= ring_dec;
        addr_q  <= AddrIn;
        valid_q <= (AddrIn != ADDR_INVALID);
        if (AddrIn == ADDR_INVALID) begin
          error_q <= 1'b1;
        end
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (Start && valid_q) begin
              if (Len != '0) begin
                state_q <= RUN;
                cnt_q   <= Len;
              end else begin
                state_q <= DONE;
              end
            end else if (Shift && valid_q) begin
              ring_q <= ring_adv;
              addr_q <= addr_adv;
              wrap_q <= (addr_q == ADDR_LAST);
            end
          end
          RUN: begin
            ring_q <= ring_adv;
            addr_q <= addr_adv;
            wrap_q <= (addr_q == ADDR_LAST);
            cnt_q  <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= DONE;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign RingOut = ring_q;
  assign AddrOut = addr_q;
  assign Valid   = valid_q;
  assign Busy    = (state_q == RUN);
  assign Done    = (state_q == DONE);
  assign Wrap    = wrap_q;
  assign Error   = error_q;

endmodule

// File: tb/tb_address_ring_decoder.sv
// Directed bench for address_ring_decoder: walks, runs, aborts, invalid loads and resets.
module tb_address_ring_decoder;

  logic        clk;
  logic        rstn;
  logic        Load;
  logic [3:0]  AddrIn;
  logic        Shift;
  logic        Start;
  logic [3:0]  Len;
  logic [14:0] RingOut;
  logic [3:0]  AddrOut;
  logic        Valid;
  logic        Busy;
  logic        Done;
  logic        Wrap;
  logic        Error;

  int checks;
  int failures;

  address_ring_decoder dut (
    .clk     (clk),
    .rstn    (rstn),
    .Load    (Load),
    .AddrIn  (AddrIn),
    .Shift   (Shift),
    .Start   (Start),
    .Len     (Len),
    .RingOut (RingOut),
    .AddrOut (AddrOut),
    .Valid   (Valid),
    .Busy    (Busy),
    .Done    (Done),
    .Wrap    (Wrap),
    .Error   (Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] obs;
  assign obs = {RingOut, AddrOut, Valid, Busy, Done, Wrap, Error};

  // Ring bit for address a is (a + 14) mod 15; address 15 has no bit.
  function automatic logic [14:0] exp_ring(input logic [3:0] a);
    int pos;
    if (a == 4'd15) return 15'd0;
    pos = (int'(a) + 14) % 15;
    return 15'(1) << pos;
  endfunction

  function automatic logic [23:0] st(input logic [3:0] a, input logic v, input logic b,
                                     input logic d, input logic w, input logic e);
    return {exp_ring(a), a, v, b, d, w, e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [23:0] exp;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    exp = {15'b100_0000_0000_0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_shift_walk();
    logic [23:0] exp;
    Shift = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      exp = st(4'(i % 15), 1'b1, 1'b0, 1'b0, (i == 15), 1'b0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL shift_walk step %0d: got %h expected %h", i, obs, exp);
      end
    end
    Shift = 1'b0;
  endtask

  task automatic test_run_len5();
    logic [23:0] exp;
    Load = 1'b1; AddrIn = 4'd12;
    tick();
    Load = 1'b0;
    Start = 1'b1; Len = 4'd5;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp = st(4'((12 + k) % 15), 1'b1, 1'b1, 1'b0, (k == 3), 1'b0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL run_len5 busy cycle %0d: got %h expected %h", k, obs, exp);
      end
      tick();
    end
    exp = st(4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL run_len5 done: got %h expected %h", obs, exp);
    end
    tick();
    exp = st(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL run_len5 idle: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_len0();
    logic [23:0] exp;
    Load = 1'b1; AddrIn = 4'd3;
    tick();
    Load = 1'b0;
    Start = 1'b1; Len = 4'd0;
    tick();
    Start = 1'b0;
    exp = st(4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL len0 done: got %h expected %h", obs, exp);
    end
    tick();
    exp = st(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL len0 idle: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_len15();
    logic [23:0] exp;
    int wraps;
    wraps = 0;
    Load = 1'b1; AddrIn = 4'd5;
    tick();
    Load = 1'b0;
    Start = 1'b1; Len = 4'd15;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (Wrap === 1'b1) wraps++;
      exp = st(4'((5 + k) % 15), 1'b1, 1'b1, 1'b0, (k == 10), 1'b0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL len15 busy cycle %0d: got %h expected %h", k, obs, exp);
      end
      tick();
    end
    if (Wrap === 1'b1) wraps++;
    exp = st(4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL len15 done: got %h expected %h", obs, exp);
    end
    checks++;
    if (wraps !== 1) begin
      failures++;
      $display("FAIL len15 wrap_count: got %0d expected 1", wraps);
    end
    tick();
  endtask

  task automatic test_ignore_in_run();
    logic [23:0] exp;
    logic [3:0]  exp_addr [5] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3};
    logic        exp_busy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        exp_done [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    Load = 1'b1; AddrIn = 4'd0;
    tick();
    Load = 1'b0;
    Start = 1'b1; Len = 4'd2; Shift = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp = st(exp_addr[k], 1'b1, exp_busy[k], exp_done[k], 1'b0, 1'b0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL ignore_in_run cycle %0d: got %h expected %h", k, obs, exp);
      end
      if (k < 4) tick();
    end
    Shift = 1'b0;
  endtask

  task automatic test_load_wrap();
    logic [23:0] exp;
    Load = 1'b1; AddrIn = 4'd14;
    tick();
    AddrIn = 4'd0;
    tick();
    Load = 1'b0;
    exp = st(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL load0_no_wrap: got %h expected %h", obs, exp);
    end
    Load = 1'b1; AddrIn = 4'd14;
    tick();
    Load = 1'b0; Shift = 1'b1;
    tick();
    Shift = 1'b0;
    exp = st(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL shift_wrap: got %h expected %h", obs, exp);
    end
    tick();
    exp = st(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL wrap_one_cycle: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_invalid();
    logic [23:0] exp;
    Load = 1'b1; AddrIn = 4'd15;
    tick();
    Load = 1'b0;
    exp = {15'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL invalid_load: got %h expected %h", obs, exp);
    end
    Start = 1'b1; Len = 4'd3;
    tick();
    Start = 1'b0;
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL invalid_start_ignored: got %h expected %h", obs, exp);
    end
    Shift = 1'b1;
    tick();
    Shift = 1'b0;
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL invalid_shift_ignored: got %h expected %h", obs, exp);
    end
    Load = 1'b1; AddrIn = 4'd7;
    tick();
    Load = 1'b0;
    exp = {15'b000_0000_0100_0000, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reload_error_sticky: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_abort();
    logic [23:0] exp;
    Start = 1'b1; Len = 4'd10;
    tick();
    Start = 1'b0;
    tick();
    tick();
    exp = st(4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL abort_third_busy: got %h expected %h", obs, exp);
    end
    Load = 1'b1; AddrIn = 4'd4; Start = 1'b1;
    tick();
    Load = 1'b0; Start = 1'b0;
    exp = {15'b000_0000_0000_1000, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL abort_idle cycle %0d: got %h expected %h", k, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    logic [23:0] exp;
    Start = 1'b1; Len = 4'd10;
    tick();
    Start = 1'b0;
    tick();
    checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_busy: got %b expected 1", Busy);
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    exp = {15'b100_0000_0000_0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL reset_midrun cycle %0d: got %h expected %h", k, obs, exp);
      end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    Load     = 1'b0;
    AddrIn   = 4'd0;
    Shift    = 1'b0;
    Start    = 1'b0;
    Len      = 4'd0;
    tick();
    test_reset();
    test_shift_walk();
    test_run_len5();
    test_len0();
    test_len15();
    test_ignore_in_run();
    test_load_wrap();
    test_invalid();
    test_abort();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
